mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Iterative multiply/divide unit with HI/LO result registers for the MIPS core. It supports MULT, MULTU, DIV and DIVU and replaces the combinational divider in the datapath. Operands come from the register file (rs, rt). Results are read back through HI/LO by the core's mfhi/mflo path. A start/busy/done handshake lets the control unit stall the pipeline while an operation is in flight.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be >= 4 and even.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a new operation; sampled only when not busy.
op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
a  input  WIDTH  operand rs (multiplicand / dividend).
b  input  WIDTH  operand rt (multiplier / divisor).
busy  output  1  operation in progress; new start ignored.
done  output  1  one-cycle pulse: hi/lo hold the new result.
div_by_zero  output  1  pulses with done when a divide had b == 0.
hi  output  WIDTH  HI register: product upper half / remainder.
lo  output  WIDTH  LO register: product lower half / quotient.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high. On a reset edge: state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
- States:
  - IDLE: busy=0.
  - CALC: busy=1; runs WIDTH cycles.
  - ADJ: busy=1; runs 1 cycle.
  - DONE: busy=0, done=1; lasts 1 cycle.
- IDLE->CALC when start=1 at a clock edge. On that edge:
  - latch op, |a|, |b| (absolute values for signed ops) and the sign flags into internal registers;
  - counter=0.
  - Input changes after the start edge have no effect.
- CALC, one bit per cycle:
  - multiply: shift-add, 2*WIDTH-bit accumulator.
  - divide: restoring division, WIDTH-bit partial remainder.
  - Increment counter each cycle. After WIDTH cycles, go to ADJ.
- ADJ: apply sign correction and form final hi/lo values internally; go to DONE.
- DONE: hi/lo are updated on the edge entering DONE; done=1 for that single cycle.
  - start=1 in DONE is accepted: go to CALC, giving back-to-back operation.
  - Otherwise go to IDLE.
- Latency: start sampled at edge k -> hi/lo update and done rise at edge k+WIDTH+2. WIDTH=32 gives 34 cycles.
- busy is high from edge k+1 until edge k+WIDTH+2.
- start while busy=1 is ignored: no queueing, no effect on the current operation.
- hi/lo hold their value between operations and change only on entry to DONE or on reset.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned per op.
- DIV/DIVU: lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero.
  - Signed remainder takes the sign of the dividend.
- Divide by zero (b==0, DIV or DIVU): lo = all ones, hi = a (as latched); div_by_zero=1 during the done cycle. Full latency still applies.
- Signed overflow (DIV, a = most-negative value, b = -1): lo = most-negative value, hi = 0, div_by_zero=0.
- Reset mid-operation (any state): return to IDLE next edge with reset values; no done pulse; the in-flight result is discarded.
- Simultaneous reset and start: reset wins; start is ignored.

Test Plan:
1. WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start edge k -> busy high k+1..k+33; done at k+34; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=0xFFFFFFF9 (-7) b=2, with start held during the DONE cycle -> accepted back-to-back; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 for exactly the done cycle. Then DIVU a=100 b=7 -> lo=14, hi=2, div_by_zero=0.
4. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_by_zero=0.
5. MULTU 7*6 started. Pulse start with op=DIVU at cycles 5 and 20, and change a/b during CALC -> all ignored; result hi=0, lo=42 at k+34.
6. MULTU started; reset asserted at cycle k+10 -> at k+11: busy=0, hi=lo=0; no done pulse within 40 further cycles. Separately, reset and start asserted on the same edge -> stays IDLE.

Source files
------------

// File: rtl/mult_div_if.sv
// Handshake and operand/result bundle between the core control/datapath and the
// iterative multiply/divide unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers: one bit per
// cycle on magnitudes, sign fix-up in a single adjust cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

  state_t             state;
  logic               busyReg;
  logic               doneReg;
  logic               dbzReg;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic [CNT_W-1:0]   counter;

  logic [1:0]         opReg;
  logic signed [WIDTH-1:0] aRaw;
  logic [WIDTH-1:0]   addend;
  logic               negA;
  logic               negB;
  logic               bZero;
  logic [2*WIDTH-1:0] acc;

  logic               loadEn;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     remShift;
  logic [WIDTH:0]     remDiff;
  logic [2*WIDTH-1:0] accNext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   adjHi;
  logic [WIDTH-1:0]   adjLo;

  function automatic logic [WIDTH-1:0] negIf(input logic [WIDTH-1:0] v, input logic neg);
    negIf = neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negIfWide(input logic [2*WIDTH-1:0] v, input logic neg);
    negIfWide = neg ? (~v + 1'b1) : v;
  endfunction

  assign loadEn = !reset && bus.start && (state == IDLE || state == DONE);

  // Iteration step: shift-add multiply or restoring divide on the shared accumulator.
  // Multiply keeps {product-high, multiplier}; divide keeps {remainder, quotient}.
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    remShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    remDiff  = remShift - {1'b0, addend};
    if (opReg[1]) begin
      accNext = remDiff[WIDTH] ? {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {remDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      accNext = acc[0] ? {mulSum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // Adjust stage: restore signs; remainder follows the dividend, quotient truncates to zero.
  always_comb begin
    product = negIfWide(acc, negA ^ negB);
    adjHi   = product[2*WIDTH-1:WIDTH];
    adjLo   = product[WIDTH-1:0];
    if (opReg[1]) begin
      if (bZero) begin
        adjHi = aRaw;
        adjLo = {WIDTH{1'b1}};
      end else begin
        adjHi = negIf(acc[2*WIDTH-1:WIDTH], negA);
        adjLo = negIf(acc[WIDTH-1:0], negA ^ negB);
      end
    end
  end

  // Operand/accumulator datapath; the control block below owns all reset behaviour.
  always_ff @(posedge clk) begin
    if (loadEn) begin
      opReg  <= bus.op;
      aRaw   <= bus.a;
      negA   <= bus.op[0] & bus.a[WIDTH-1];
      negB   <= bus.op[0] & bus.b[WIDTH-1];
      bZero  <= (bus.b == '0);
      addend <= bus.op[1] ? negIf(bus.b, bus.op[0] & bus.b[WIDTH-1])
                          : negIf(bus.a, bus.op[0] & bus.a[WIDTH-1]);
      acc    <= {{WIDTH{1'b0}},
                 bus.op[1] ? negIf(bus.a, bus.op[0] & bus.a[WIDTH-1])
                           : negIf(bus.b, bus.op[0] & bus.b[WIDTH-1])};
    end else if (state == CALC) begin
      acc <= accNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      counter <= '0;
    end else begin
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state   <= CALC;
            busyReg <= 1'b1;
            counter <= '0;
          end else begin
            state   <= IDLE;
            busyReg <= 1'b0;
          end
        end
        CALC: begin
          counter <= counter + 1'b1;
          if (counter == CNT_W'(WIDTH - 1)) state <= ADJ;
        end
        ADJ: begin
          hiReg   <= adjHi;
          loReg   <= adjLo;
          doneReg <= 1'b1;
          dbzReg  <= opReg[1] & bZero;
          busyReg <= 1'b0;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busyReg;
  assign bus.done        = doneReg;
  assign bus.div_by_zero = dbzReg;
  assign bus.hi          = hiReg;
  assign bus.lo          = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/div_by_zero pushed at start,
// popped and compared when done is observed.
module tb_mult_div_unit;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   nCmp = 0;
  int   nFail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sbv, q, r;
    logic [2*W-1:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.dbz = 1'b0;
    case (op)
      2'b00: begin
        p = {32'b0, a} * {32'b0, b};
        e.hi = p[2*W-1:W]; e.lo = p[W-1:0];
      end
      2'b01: begin
        p = 64'(sa * sbv);
        e.hi = p[2*W-1:W]; e.lo = p[W-1:0];
      end
      default: begin
        if (b == '0) begin
          e.hi = a; e.lo = '1; e.dbz = 1'b1;
        end else if (op == 2'b10) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          q = sa / sbv; r = sa % sbv;
          e.lo = q[W-1:0]; e.hi = r[W-1:0];
        end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge; returns just after the start edge with inputs scrambled.
  task automatic startOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.a = $urandom(); bus.b = $urandom(); bus.op = 2'($urandom_range(3));
  endtask

  // n = k+n edge index of the observation; stops at the negedge where done is seen.
  task automatic waitDone(output int cycles, output int busyCnt, output int dbzStray, output logic timedOut);
    cycles = 0; busyCnt = 0; dbzStray = 0; timedOut = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      cycles = n;
      if (bus.done) begin
        timedOut = 1'b0;
        break;
      end
      if (bus.busy) busyCnt++;
      if (bus.div_by_zero) dbzStray++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    nCmp++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    nCmp++; if (bus.done !== 1'b0) begin nFail++; $display("FAIL reset_done got %0b want 0", bus.done); end
    nCmp++; if (bus.div_by_zero !== 1'b0) begin nFail++; $display("FAIL reset_dbz got %0b want 0", bus.div_by_zero); end
    nCmp++; if ({bus.hi, bus.lo} !== 64'h0) begin nFail++; $display("FAIL reset_hilo got %h want 0", {bus.hi, bus.lo}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ops();
    logic [1:0]   ops[13];
    logic [W-1:0] as[13];
    logic [W-1:0] bs[13];
    int cycles, busyCnt, dbzStray;
    logic timedOut;
    exp_t e;
    ops = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3};
    as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000,
            32'h8000_0000, 32'd7, 32'hFFFF_FF9C, 32'h7FFF_FFFF, $urandom(), $urandom(), $urandom()};
    bs  = '{32'hFFFF_FFFF, 32'd5, 32'd0, 32'd7, 32'hFFFF_FFFF, 32'd0,
            32'h8000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFFF, $urandom(), $urandom() | 32'h1, $urandom() >> 20};
    for (int i = 0; i < 13; i++) begin
      startOp(ops[i], as[i], bs[i]);
      waitDone(cycles, busyCnt, dbzStray, timedOut);
      e = sb.pop_front();
      nCmp++; if (timedOut) begin nFail++; $display("FAIL op%0d_timeout no done within 100 cycles", i); end
      nCmp++; if (cycles !== W + 2) begin nFail++; $display("FAIL op%0d_latency got %0d want %0d", i, cycles, W + 2); end
      nCmp++; if (busyCnt !== W + 1) begin nFail++; $display("FAIL op%0d_busy got %0d want %0d", i, busyCnt, W + 1); end
      nCmp++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL op%0d_busy_done got %0b want 0", i, bus.busy); end
      nCmp++; if (bus.hi !== e.hi) begin nFail++; $display("FAIL op%0d_hi got %h want %h", i, bus.hi, e.hi); end
      nCmp++; if (bus.lo !== e.lo) begin nFail++; $display("FAIL op%0d_lo got %h want %h", i, bus.lo, e.lo); end
      nCmp++; if (bus.div_by_zero !== e.dbz) begin nFail++; $display("FAIL op%0d_dbz got %0b want %0b", i, bus.div_by_zero, e.dbz); end
      nCmp++; if (dbzStray !== 0) begin nFail++; $display("FAIL op%0d_dbz_early got %0d want 0", i, dbzStray); end
      @(negedge clk);
      nCmp++; if ({bus.done, bus.div_by_zero} !== 2'b00) begin nFail++; $display("FAIL op%0d_pulse got %b want 00", i, {bus.done, bus.div_by_zero}); end
      nCmp++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin nFail++; $display("FAIL op%0d_hold got %h_%h want %h_%h", i, bus.hi, bus.lo, e.hi, e.lo); end
    end
  endtask

  task automatic test_back_to_back();
    int cycles, busyCnt, dbzStray;
    logic timedOut;
    exp_t e;
    startOp(2'd1, 32'hFFFF_FFFD, 32'd5);
    waitDone(cycles, busyCnt, dbzStray, timedOut);
    e = sb.pop_front();
    nCmp++; if (timedOut || bus.hi !== e.hi || bus.lo !== e.lo) begin nFail++; $display("FAIL b2b_first got %h_%h want %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
    startOp(2'd3, 32'hFFFF_FFF9, 32'd2);
    waitDone(cycles, busyCnt, dbzStray, timedOut);
    e = sb.pop_front();
    nCmp++; if (cycles !== W + 2) begin nFail++; $display("FAIL b2b_latency got %0d want %0d", cycles, W + 2); end
    nCmp++; if (bus.lo !== e.lo) begin nFail++; $display("FAIL b2b_lo got %h want %h", bus.lo, e.lo); end
    nCmp++; if (bus.hi !== e.hi) begin nFail++; $display("FAIL b2b_hi got %h want %h", bus.hi, e.hi); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int cycles, extraBusy;
    exp_t e;
    startOp(2'd0, 32'd7, 32'd6);
    cycles = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.done) begin cycles = n; break; end
      bus.start = (n == 5 || n == 20);
      bus.op = 2'd2;
      bus.a = $urandom(); bus.b = $urandom();
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    nCmp++; if (cycles !== W + 2) begin nFail++; $display("FAIL ignore_latency got %0d want %0d", cycles, W + 2); end
    nCmp++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin nFail++; $display("FAIL ignore_result got %h_%h want %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
    extraBusy = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.done) extraBusy++;
    end
    nCmp++; if (extraBusy !== 0) begin nFail++; $display("FAIL ignore_queued got %0d busy cycles want 0", extraBusy); end
  endtask

  task automatic test_reset_mid();
    int doneCnt;
    startOp(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    void'(sb.pop_back());
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    nCmp++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL rstmid_busy got %0b want 0", bus.busy); end
    nCmp++; if ({bus.hi, bus.lo} !== 64'h0) begin nFail++; $display("FAIL rstmid_hilo got %h want 0", {bus.hi, bus.lo}); end
    reset = 1'b0;
    doneCnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) doneCnt++;
    end
    nCmp++; if (doneCnt !== 0) begin nFail++; $display("FAIL rstmid_done got %0d active cycles want 0", doneCnt); end
  endtask

  task automatic test_reset_start();
    int active;
    reset = 1'b1; bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd3; bus.b = 32'd3;
    @(negedge clk);
    reset = 1'b0; bus.start = 1'b0;
    active = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) active++;
    end
    nCmp++; if (active !== 0) begin nFail++; $display("FAIL rststart_idle got %0d active cycles want 0", active); end
    nCmp++; if ({bus.hi, bus.lo} !== 64'h0) begin nFail++; $display("FAIL rststart_hilo got %h want 0", {bus.hi, bus.lo}); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_reset_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
